// File: rtl/effects_chain.sv
// Overdrive effects chain: input gain, symmetric clipper, output level and final saturation
// in a 3-stage valid pipeline. Optional noise gate under EFFECTS_CHAIN_NOISE_GATE_EN.
module effects_chain #(
   parameter int IN_W      = 12,
   parameter int OUT_W     = 16,
   parameter int GAIN_W    = 11,
   parameter int GAIN_FRAC = 4,
   parameter int LEVEL_W   = 8
`ifdef EFFECTS_CHAIN_NOISE_GATE_EN
   ,
   parameter int GATE_THR  = 16,
   parameter int GATE_HOLD = 1024
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic [IN_W-1:0]     in_sample,
   input  logic                par_load,
   input  logic [GAIN_W-1:0]   par_gain,
   input  logic [OUT_W-2:0]    par_clip,
   input  logic [LEVEL_W-1:0]  par_level,
   input  logic                par_bypass,
   output logic                par_pending,
   output logic                out_valid,
   output logic [OUT_W-1:0]    out_sample,
   output logic                out_clipped
);

   localparam int PW = OUT_W + GAIN_W + 1;
   localparam int QW = OUT_W + LEVEL_W + 1;

   localparam logic [GAIN_W-1:0]  GAIN_UNITY  = GAIN_W'(1 << GAIN_FRAC);
   localparam logic [OUT_W-2:0]   CLIP_MAX    = '1;
   localparam logic [LEVEL_W-1:0] LEVEL_UNITY = LEVEL_W'(1 << (LEVEL_W - 1));

   localparam logic signed [QW-1:0] SAT_MAX = {{(QW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [QW-1:0] SAT_MIN = {{(QW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // ---------------- parameter sets ----------------
   logic [GAIN_W-1:0]  r_act_gain,  r_pnd_gain;
   logic [OUT_W-2:0]   r_act_clip,  r_pnd_clip;
   logic [LEVEL_W-1:0] r_act_level, r_pnd_level;
   logic               r_act_byp,   r_pnd_byp;
   logic               r_pending;

   logic               w_apply;
   logic [GAIN_W-1:0]  w_sel_gain;
   logic [OUT_W-2:0]   w_sel_clip;
   logic [LEVEL_W-1:0] w_sel_level;
   logic               w_sel_byp;

   assign w_apply     = in_valid & r_pending;
   assign w_sel_gain  = w_apply ? r_pnd_gain  : r_act_gain;
   assign w_sel_clip  = w_apply ? r_pnd_clip  : r_act_clip;
   assign w_sel_level = w_apply ? r_pnd_level : r_act_level;
   assign w_sel_byp   = w_apply ? r_pnd_byp   : r_act_byp;

   // A load coinciding with an applying sample promotes the old pending set and re-arms.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_gain  <= GAIN_UNITY;
         r_act_clip  <= CLIP_MAX;
         r_act_level <= LEVEL_UNITY;
         r_act_byp   <= 1'b0;
         r_pnd_gain  <= GAIN_UNITY;
         r_pnd_clip  <= CLIP_MAX;
         r_pnd_level <= LEVEL_UNITY;
         r_pnd_byp   <= 1'b0;
         r_pending   <= 1'b0;
      end else begin
         if (w_apply) begin
            r_act_gain  <= r_pnd_gain;
            r_act_clip  <= r_pnd_clip;
            r_act_level <= r_pnd_level;
            r_act_byp   <= r_pnd_byp;
         end
         if (par_load) begin
            r_pnd_gain  <= par_gain;
            r_pnd_clip  <= par_clip;
            r_pnd_level <= par_level;
            r_pnd_byp   <= par_bypass;
            r_pending   <= 1'b1;
         end else if (w_apply) begin
            r_pending   <= 1'b0;
         end
      end
   end

   assign par_pending = r_pending;

   // ---------------- stage 1: extend and snapshot ----------------
   logic signed [OUT_W-1:0] w_x_ext;
   assign w_x_ext = OUT_W'($signed(in_sample));

   logic                    r_s1_valid;
   logic signed [OUT_W-1:0] r_s1_x;
   logic [GAIN_W-1:0]       r_s1_gain;
   logic [OUT_W-2:0]        r_s1_clip;
   logic [LEVEL_W-1:0]      r_s1_level;
   logic                    r_s1_byp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_x     <= '0;
         r_s1_gain  <= '0;
         r_s1_clip  <= '0;
         r_s1_level <= '0;
         r_s1_byp   <= 1'b0;
      end else begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_x     <= w_x_ext;
            r_s1_gain  <= w_sel_gain;
            r_s1_clip  <= w_sel_clip;
            r_s1_level <= w_sel_level;
            r_s1_byp   <= w_sel_byp;
         end
      end
   end

   // ---------------- optional noise gate ----------------
   logic w_s2_mute;

`ifdef EFFECTS_CHAIN_NOISE_GATE_EN
   localparam int CW = $clog2(GATE_HOLD + 1);
   localparam logic [OUT_W-1:0] THR    = OUT_W'(GATE_THR);
   localparam logic [CW-1:0]    HOLD_N = CW'(GATE_HOLD);

   typedef enum logic [1:0] {G_OPEN, G_HOLD, G_CLOSED} gate_t;

   gate_t            r_gate_state, w_gate_next;
   logic [CW-1:0]    r_gate_cnt,   w_cnt_next;
   logic [CW-1:0]    w_cnt_inc;
   logic [OUT_W-1:0] w_abs;
   logic             w_loud;
   logic             r_s1_mute, r_s2_mute;

   assign w_abs     = w_x_ext[OUT_W-1] ? OUT_W'(-w_x_ext) : OUT_W'(w_x_ext);
   assign w_loud    = (w_abs >= THR);
   assign w_cnt_inc = r_gate_cnt + CW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gate_state <= G_OPEN;
         r_gate_cnt   <= '0;
      end else begin
         r_gate_state <= w_gate_next;
         r_gate_cnt   <= w_cnt_next;
      end
   end

   always_comb begin
      w_gate_next = r_gate_state;
      w_cnt_next  = r_gate_cnt;
      if (in_valid) begin
         case (r_gate_state)
            G_OPEN: begin
               if (!w_loud) begin
                  w_gate_next = G_HOLD;
                  w_cnt_next  = CW'(1);
               end
            end
            G_HOLD: begin
               if (w_loud) begin
                  w_gate_next = G_OPEN;
                  w_cnt_next  = '0;
               end else begin
                  w_cnt_next = w_cnt_inc;
                  if (w_cnt_inc == HOLD_N) w_gate_next = G_CLOSED;
               end
            end
            G_CLOSED: begin
               if (w_loud) begin
                  w_gate_next = G_OPEN;
                  w_cnt_next  = '0;
               end
            end
            default: begin
               w_gate_next = G_OPEN;
               w_cnt_next  = '0;
            end
         endcase
      end
   end

   // Each sample carries the gate state it produced.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_mute <= 1'b0;
         r_s2_mute <= 1'b0;
      end else begin
         if (in_valid)   r_s1_mute <= (w_gate_next == G_CLOSED);
         if (r_s1_valid) r_s2_mute <= r_s1_mute;
      end
   end

   assign w_s2_mute = r_s2_mute;
`else
   assign w_s2_mute = 1'b0;
`endif

   // ---------------- stage 2: gain and clip ----------------
   logic signed [PW-1:0]    w_pa, w_pb, w_p, w_p_sh, w_clip_pos, w_clip_neg;
   logic signed [OUT_W-1:0] w_y;
   logic                    w_y_tag;

   assign w_pa       = PW'(r_s1_x);
   assign w_pb       = PW'($signed({1'b0, r_s1_gain}));
   assign w_p        = w_pa * w_pb;
   assign w_p_sh     = w_p >>> GAIN_FRAC;
   assign w_clip_pos = PW'({1'b0, r_s1_clip});
   assign w_clip_neg = -w_clip_pos;

   // Zero threshold flags every non-zero input, even if the scaled value rounds to zero.
   always_comb begin
      w_y     = w_p_sh[OUT_W-1:0];
      w_y_tag = 1'b0;
      if (w_p_sh > w_clip_pos) begin
         w_y     = w_clip_pos[OUT_W-1:0];
         w_y_tag = 1'b1;
      end else if (w_p_sh < w_clip_neg) begin
         w_y     = w_clip_neg[OUT_W-1:0];
         w_y_tag = 1'b1;
      end
      if ((r_s1_clip == '0) && (r_s1_x != '0)) w_y_tag = 1'b1;
      if (r_s1_byp) begin
         w_y     = r_s1_x;
         w_y_tag = 1'b0;
      end
   end

   logic                    r_s2_valid;
   logic signed [OUT_W-1:0] r_s2_y;
   logic                    r_s2_tag;
   logic [LEVEL_W-1:0]      r_s2_level;
   logic                    r_s2_byp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_y     <= '0;
         r_s2_tag   <= 1'b0;
         r_s2_level <= '0;
         r_s2_byp   <= 1'b0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_y     <= w_y;
            r_s2_tag   <= w_y_tag;
            r_s2_level <= r_s1_level;
            r_s2_byp   <= r_s1_byp;
         end
      end
   end

   // ---------------- stage 3: level and saturate ----------------
   logic signed [QW-1:0]    w_qa, w_qb, w_q, w_q_sh;
   logic signed [OUT_W-1:0] w_out;
   logic                    w_out_tag;

   assign w_qa   = QW'(r_s2_y);
   assign w_qb   = QW'($signed({1'b0, r_s2_level}));
   assign w_q    = w_qa * w_qb;
   assign w_q_sh = w_q >>> (LEVEL_W - 1);

   always_comb begin
      w_out     = w_q_sh[OUT_W-1:0];
      w_out_tag = r_s2_tag;
      if (w_q_sh > SAT_MAX) begin
         w_out     = SAT_MAX[OUT_W-1:0];
         w_out_tag = 1'b1;
      end else if (w_q_sh < SAT_MIN) begin
         w_out     = SAT_MIN[OUT_W-1:0];
         w_out_tag = 1'b1;
      end
      if (r_s2_byp) begin
         w_out     = r_s2_y;
         w_out_tag = 1'b0;
      end
      if (w_s2_mute) begin
         w_out     = '0;
         w_out_tag = 1'b0;
      end
   end

   logic             r_out_valid;
   logic [OUT_W-1:0] r_out_sample;
   logic             r_out_clipped;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid   <= 1'b0;
         r_out_sample  <= '0;
         r_out_clipped <= 1'b0;
      end else begin
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_out_sample  <= w_out;
            r_out_clipped <= w_out_tag;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_sample  = r_out_sample;
   assign out_clipped = r_out_clipped;

endmodule

// File: tb/tb_effects_chain.sv
// Directed self-checking bench for effects_chain; gate vectors run when
// EFFECTS_CHAIN_NOISE_GATE_EN is defined.
module tb_effects_chain;

   localparam int IN_W      = 12;
   localparam int OUT_W     = 16;
   localparam int GAIN_W    = 11;
   localparam int GAIN_FRAC = 4;
   localparam int LEVEL_W   = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic [IN_W-1:0]    in_sample;
   logic               par_load;
   logic [GAIN_W-1:0]  par_gain;
   logic [OUT_W-2:0]   par_clip;
   logic [LEVEL_W-1:0] par_level;
   logic               par_bypass;
   logic               par_pending;
   logic               out_valid;
   logic [OUT_W-1:0]   out_sample;
   logic               out_clipped;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   effects_chain #(
      .IN_W(IN_W),
      .OUT_W(OUT_W),
      .GAIN_W(GAIN_W),
      .GAIN_FRAC(GAIN_FRAC),
      .LEVEL_W(LEVEL_W)
`ifdef EFFECTS_CHAIN_NOISE_GATE_EN
      ,
      .GATE_THR(16),
      .GATE_HOLD(4)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_sample(in_sample),
      .par_load(par_load),
      .par_gain(par_gain),
      .par_clip(par_clip),
      .par_level(par_level),
      .par_bypass(par_bypass),
      .par_pending(par_pending),
      .out_valid(out_valid),
      .out_sample(out_sample),
      .out_clipped(out_clipped)
   );

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_par(input int gain, input int clip, input int level, input logic byp);
      @(posedge clk); #1;
      par_load   = 1'b1;
      par_gain   = GAIN_W'(gain);
      par_clip   = (OUT_W-1)'(clip);
      par_level  = LEVEL_W'(level);
      par_bypass = byp;
      @(posedge clk); #1;
      par_load = 1'b0;
      check("pending_set", par_pending, 1);
   endtask

   // Single sample: out_valid must be low two edges after capture and high on the third.
   task automatic run_sample(input string tag, input int x, input int exp, input logic expc);
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_sample = IN_W'(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "_early"}, out_valid, 0);
      @(posedge clk); #1;
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sample"}, $signed(out_sample), exp);
      check({tag, "_clip"}, out_clipped, expc);
      check({tag, "_pend"}, par_pending, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_sample  = '0;
      par_load   = 1'b0;
      par_gain   = '0;
      par_clip   = '0;
      par_level  = '0;
      par_bypass = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_sample", $signed(out_sample), 0);
      check("rst_clip", out_clipped, 0);
      check("rst_pend", par_pending, 0);
      rst = 1'b0;

      // defaults are unity gain/level, max clip
      run_sample("t1", 1024, 1024, 1'b0);

      // gain x4 with clip 3000
      load_par(16'h040, 3000, 128, 1'b0);
      run_sample("t2a", 1024, 3000, 1'b1);
      run_sample("t2b", -500, -2000, 1'b0);

      // level 255/128
      load_par(16'h040, 32767, 255, 1'b0);
      run_sample("t3a", 2047, 16312, 1'b0);
      load_par(16'h3FF, 32767, 255, 1'b0);
      run_sample("t3b", 2047, 32767, 1'b1);
      run_sample("t3c", -2048, -32768, 1'b1);

      // gain 1.5: -3*1.5 = -4.5 floors to -5
      load_par(16'h018, 32767, 128, 1'b0);
      run_sample("trunc", -3, -5, 1'b0);

      // zero clip threshold
      load_par(16'h010, 0, 128, 1'b0);
      run_sample("clip0a", 5, 0, 1'b1);
      run_sample("clip0b", 0, 0, 1'b0);

      // coherent update in a continuous stream
      load_par(16'h010, 32767, 128, 1'b0);
      run_sample("t4pre", 7, 7, 1'b0);
      @(posedge clk); #1;
      for (int j = 0; j < 13; j++) begin
         if (j < 3) begin
            check("t4_idle", out_valid, 0);
         end else begin
            check($sformatf("t4_valid%0d", j - 3), out_valid, 1);
            check($sformatf("t4_sample%0d", j - 3), $signed(out_sample),
                  (j - 3 <= 4) ? 100 : 200);
         end
         if (j == 4) check("t4_pend_before", par_pending, 0);
         if (j == 5) check("t4_pend_load", par_pending, 1);
         if (j == 6) check("t4_pend_clear", par_pending, 0);
         in_valid  = (j < 10);
         in_sample = IN_W'(100);
         par_load  = (j == 4);
         par_gain  = GAIN_W'(16'h020);
         par_clip  = (OUT_W-1)'(32767);
         par_level = LEVEL_W'(128);
         par_bypass = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      par_load = 1'b0;

      // bypass
      load_par(16'h3FF, 100, 255, 1'b1);
      run_sample("t5byp", -2048, -2048, 1'b0);
      check("t5byp_hex", out_sample, 32'h0000F800);

      // reset with two samples in flight and a pending set
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_sample = IN_W'(50);
      @(posedge clk); #1;
      in_sample  = IN_W'(60);
      par_load   = 1'b1;
      par_gain   = GAIN_W'(16'h020);
      par_clip   = (OUT_W-1)'(32767);
      par_level  = LEVEL_W'(128);
      par_bypass = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      par_load = 1'b0;
      check("t5_pend_pre", par_pending, 1);
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_valid", out_valid, 0);
      check("t5_rst_sample", $signed(out_sample), 0);
      check("t5_rst_clip", out_clipped, 0);
      check("t5_rst_pend", par_pending, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         check("t5_no_valid", out_valid, 0);
      end
      run_sample("t5post", 1024, 1024, 1'b0);

`ifdef EFFECTS_CHAIN_NOISE_GATE_EN
      run_sample("gate1", 3, 3, 1'b0);
      run_sample("gate2", 3, 3, 1'b0);
      run_sample("gate3", 3, 3, 1'b0);
      run_sample("gate4", 3, 0, 1'b0);
      run_sample("gate5", 3, 0, 1'b0);
      run_sample("gate_open", 20, 20, 1'b0);
      run_sample("gate_again", 3, 3, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
